scaler_request_sequencer: RTL and testbench

Frame-level request scheduler that drives the downstream request FIFO of the aggregate scaler pipeline (crop, integer scale, stretch, pad) with (row, chunk) requests in raster order. It limits outstanding chunks using a credit scheme, so that the downstream response FIFO never holds more pixels than the consumer has room for. It sits between the display timing logic (frame start, pixel consume strobes) and the scaler's downstream-side FIFOs.

---
 rtl/scaler_pipeline_pkg.sv | 46 ++++
 rtl/scaler_request_sequencer_if.sv | 23 ++
 rtl/scaler_chunk_credit_counter.sv | 49 ++++
 rtl/scaler_request_sequencer.sv | 156 +++++++++++++++
 tb/tb_scaler_request_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/scaler_pipeline_pkg.sv
// Shared types and sizing for the aggregate scaler pipeline (crop, scale, stretch, pad).
// Contents: raster geometry widths, chunk/request widths, request pack/unpack helpers,
//           and the request sequencer FSM state encoding.
package scaler_pipeline_pkg;

  localparam int HACTIVE_BITS       = 11;
  localparam int VACTIVE_BITS       = 11;
  localparam int BITS_PER_PIXEL     = 16;
  localparam int DEFAULT_CHUNK_BITS = 5;

  // A row of up to 2^HACTIVE_BITS pixels holds 2^(HACTIVE_BITS-chunk_bits) chunks.
  function automatic int chunknum_bits(input int chunk_bits);
    return HACTIVE_BITS - chunk_bits;
  endfunction

  localparam int CHUNKNUM_BITS      = chunknum_bits(DEFAULT_CHUNK_BITS);
  localparam int REQUEST_BITS       = VACTIVE_BITS + CHUNKNUM_BITS;
  localparam int MAX_CHUNKS_PER_ROW = 1 << CHUNKNUM_BITS;

  typedef struct packed {
    logic [VACTIVE_BITS-1:0]  row;
    logic [CHUNKNUM_BITS-1:0] chunk;
  } request_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  function automatic logic [REQUEST_BITS-1:0] pack_request(
    input logic [VACTIVE_BITS-1:0]  row,
    input logic [CHUNKNUM_BITS-1:0] chunk
  );
    request_t r;
    r.row   = row;
    r.chunk = chunk;
    return r;
  endfunction

  function automatic request_t unpack_request(input logic [REQUEST_BITS-1:0] bits);
    return request_t'(bits);
  endfunction

endpackage

// File: rtl/scaler_request_sequencer_if.sv
// Request FIFO write port between the request sequencer and the scaler's downstream FIFO.
// Signals: requestFifoWriteEnable/requestFifoWriteData (sequencer -> FIFO),
//          requestFifoFull (FIFO -> sequencer, registered in the FIFO, almost-full-by-one).
interface scaler_request_sequencer_if;
  import scaler_pipeline_pkg::*;

  logic                    requestFifoWriteEnable;
  logic [REQUEST_BITS-1:0] requestFifoWriteData;
  logic                    requestFifoFull;

  modport master (
    output requestFifoWriteEnable,
    output requestFifoWriteData,
    input  requestFifoFull
  );

  modport slave (
    input  requestFifoWriteEnable,
    input  requestFifoWriteData,
    output requestFifoFull
  );

endinterface

// File: rtl/scaler_chunk_credit_counter.sv
// Purpose: tracks requested-but-not-consumed chunks; a chunk is retired after CHUNK_SIZE consumes.
// Latency: outstanding updates on the edge after issue / final pixel consume.
// Backpressure: creditAvailable drops at MAX_OUTSTANDING; consumes with nothing outstanding are ignored.
// Ports: scalerClock, reset (async active-low), issue, pixelConsumed -> outstanding, creditAvailable.
module scaler_chunk_credit_counter #(
  parameter int CHUNK_BITS      = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       scalerClock,
  input  logic       reset,
  input  logic       issue,
  input  logic       pixelConsumed,
  output logic [3:0] outstanding,
  output logic       creditAvailable
);

  localparam logic [CHUNK_BITS-1:0] PIX_ONE = 1;
  localparam logic [3:0]            MAX_OUT = 4'(MAX_OUTSTANDING);

  logic [CHUNK_BITS-1:0] r_pix;
  logic [3:0]            r_out;
  logic                  w_take;
  logic                  w_wrap;

  // Stray consume strobes with no chunk in flight must not skew the pixel phase.
  assign w_take = pixelConsumed && (r_out != 4'd0);
  assign w_wrap = w_take && (r_pix == {CHUNK_BITS{1'b1}});

  always_ff @(posedge scalerClock or negedge reset) begin
    if (!reset) begin
      r_pix <= '0;
      r_out <= 4'd0;
    end else begin
      if (w_take) begin
        r_pix <= r_pix + PIX_ONE;
      end
      // Simultaneous issue and retire cancel out.
      case ({issue, w_wrap})
        2'b10:   r_out <= r_out + 4'd1;
        2'b01:   r_out <= r_out - 4'd1;
        default: r_out <= r_out;
      endcase
    end
  end

  assign outstanding     = r_out;
  assign creditAvailable = (r_out < MAX_OUT);

endmodule

// File: rtl/scaler_request_sequencer.sv
// Purpose: issues (row, chunk) requests in raster order for one frame, credit-limited.
// Latency: first write 2 cycles after frameStart; empty frame gives frameDone 2 cycles after frameStart.
// Backpressure: no write decided in a cycle with requestFifoFull or with MAX_OUTSTANDING chunks in flight.
// Ports: scalerClock, reset (async active-low), frameStart/activeRows/activeChunks (frame config),
//        reqIf (request FIFO write port), pixelConsumed (consumer strobe), busy/frameDone/frameOverrun.
module scaler_request_sequencer
  import scaler_pipeline_pkg::*;
#(
  parameter int CHUNK_BITS      = DEFAULT_CHUNK_BITS,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     scalerClock,
  input  logic                     reset,
  input  logic                     frameStart,
  input  logic [VACTIVE_BITS-1:0]  activeRows,
  input  logic [CHUNKNUM_BITS:0]   activeChunks,
  scaler_request_sequencer_if.master reqIf,
  input  logic                     pixelConsumed,
  output logic                     busy,
  output logic                     frameDone,
  output logic                     frameOverrun
);

  seq_state_t                r_state,      w_state_nxt;
  logic [VACTIVE_BITS-1:0]   r_lat_rows,   w_lat_rows_nxt;
  logic [CHUNKNUM_BITS:0]    r_lat_chunks, w_lat_chunks_nxt;
  logic [VACTIVE_BITS-1:0]   r_row,        w_row_nxt;
  logic [CHUNKNUM_BITS-1:0]  r_chunk,      w_chunk_nxt;
  logic                      r_wr_en,      w_wr_en_nxt;
  logic [REQUEST_BITS-1:0]   r_wr_dat,     w_wr_dat_nxt;
  logic                      r_busy,       w_busy_nxt;
  logic                      r_done,       w_done_nxt;
  logic                      r_overrun,    w_overrun_nxt;

  logic       w_issue;
  logic       w_credit;
  logic [3:0] w_outstanding;
  logic       w_last_chunk;
  logic       w_last_row;

  scaler_chunk_credit_counter #(
    .CHUNK_BITS      (CHUNK_BITS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .scalerClock     (scalerClock),
    .reset           (reset),
    .issue           (w_issue),
    .pixelConsumed   (pixelConsumed),
    .outstanding     (w_outstanding),
    .creditAvailable (w_credit)
  );

  // Full is already registered in the FIFO and leaves one slot of slack, so it gates directly.
  assign w_issue      = (r_state == ST_ISSUE) && !reqIf.requestFifoFull && w_credit;
  assign w_last_chunk = ({1'b0, r_chunk} == (r_lat_chunks - 7'd1));
  assign w_last_row   = (r_row == (r_lat_rows - 11'd1));

  always_comb begin
    w_state_nxt      = r_state;
    w_lat_rows_nxt   = r_lat_rows;
    w_lat_chunks_nxt = r_lat_chunks;
    w_row_nxt        = r_row;
    w_chunk_nxt      = r_chunk;
    w_wr_en_nxt      = 1'b0;
    w_wr_dat_nxt     = r_wr_dat;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    // busy stays high through the frameDone cycle, so a start landing there is also an overrun.
    w_overrun_nxt    = frameStart && (r_busy || (r_state != ST_IDLE));

    case (r_state)
      ST_IDLE: begin
        // First IDLE cycle after DONE: busy falls together with frameDone.
        if (r_busy) begin
          w_busy_nxt = 1'b0;
        end else if (frameStart) begin
          w_lat_rows_nxt   = activeRows;
          w_lat_chunks_nxt = activeChunks;
          w_row_nxt        = '0;
          w_chunk_nxt      = '0;
          w_busy_nxt       = 1'b1;
          if ((activeRows == '0) || (activeChunks == '0)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        if (w_issue) begin
          w_wr_en_nxt  = 1'b1;
          w_wr_dat_nxt = pack_request(r_row, r_chunk);
          if (w_last_chunk) begin
            w_chunk_nxt = '0;
            if (w_last_row) begin
              w_state_nxt = ST_DRAIN;
            end else begin
              w_row_nxt = r_row + 11'd1;
            end
          end else begin
            w_chunk_nxt = r_chunk + 6'd1;
          end
        end
      end

      ST_DRAIN: begin
        if (w_outstanding == 4'd0) begin
          w_state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge scalerClock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_lat_rows   <= '0;
      r_lat_chunks <= '0;
      r_row        <= '0;
      r_chunk      <= '0;
      r_wr_en      <= 1'b0;
      r_wr_dat     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lat_rows   <= w_lat_rows_nxt;
      r_lat_chunks <= w_lat_chunks_nxt;
      r_row        <= w_row_nxt;
      r_chunk      <= w_chunk_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_wr_dat     <= w_wr_dat_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  assign reqIf.requestFifoWriteEnable = r_wr_en;
  assign reqIf.requestFifoWriteData   = r_wr_dat;
  assign busy                         = r_busy;
  assign frameDone                    = r_done;
  assign frameOverrun                 = r_overrun;

endmodule

// File: tb/tb_scaler_request_sequencer.sv
module tb_scaler_request_sequencer;

  logic        clk;
  logic        rst_n;
  logic        frameStart;
  logic [10:0] activeRows;
  logic [6:0]  activeChunks;
  logic        pixelConsumed;
  logic        busy;
  logic        frameDone;
  logic        frameOverrun;

  scaler_request_sequencer_if rq ();

  scaler_request_sequencer #(
    .CHUNK_BITS      (5),
    .MAX_OUTSTANDING (4)
  ) dut (
    .scalerClock   (clk),
    .reset         (rst_n),
    .frameStart    (frameStart),
    .activeRows    (activeRows),
    .activeChunks  (activeChunks),
    .reqIf         (rq.master),
    .pixelConsumed (pixelConsumed),
    .busy          (busy),
    .frameDone     (frameDone),
    .frameOverrun  (frameOverrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          n_writes = 0;
  int          done_cnt = 0;
  int          ovr_cnt  = 0;
  logic [16:0] last_wr  = '0;
  bit          check_full = 1'b0;
  logic [16:0] exp_q[$];

  task automatic chk(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge and scores every request write.
  always begin
    logic        full_at_edge;
    logic [16:0] got;
    logic [16:0] want;
    @(posedge clk);
    full_at_edge = rq.requestFifoFull;
    #1;
    if (frameDone)    done_cnt++;
    if (frameOverrun) ovr_cnt++;
    if (rq.requestFifoWriteEnable === 1'b1) begin
      got = rq.requestFifoWriteData;
      n_writes++;
      last_wr = got;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got %05h, expected no write", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_bad++;
          $display("FAIL request_data: got %05h, expected %05h", got, want);
        end
      end
      if (check_full) begin
        n_cmp++;
        if (full_at_edge) begin
          n_bad++;
          $display("FAIL write_after_full: got write after full=1, expected none");
        end
      end
    end
  end

  task automatic push_frame(input int rows, input int chunks);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < chunks; c++)
        exp_q.push_back(17'((r << 6) | c));
  endtask

  // Pulses frameStart for one cycle; returns at the negedge of the following cycle.
  task automatic start_frame(input int rows, input int chunks);
    @(negedge clk);
    frameStart   = 1'b1;
    activeRows   = 11'(rows);
    activeChunks = 7'(chunks);
    @(negedge clk);
    frameStart   = 1'b0;
  endtask

  task automatic run_frame(input string name, input int budget, input bit consume,
                           input bit toggle_full, input bit inject);
    int d0;
    bit injected;
    d0 = done_cnt;
    injected = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != d0) break;
      pixelConsumed = consume;
      if (toggle_full) rq.requestFifoFull = ~rq.requestFifoFull;
      if (inject && !injected && last_wr == 17'h00041) begin
        frameStart   = 1'b1;
        activeRows   = 11'd7;
        activeChunks = 7'd1;
        injected     = 1'b1;
      end else begin
        frameStart = 1'b0;
      end
    end
    pixelConsumed      = 1'b0;
    rq.requestFifoFull = 1'b0;
    frameStart         = 1'b0;
    chk({name, "_frame_done"}, done_cnt - d0, 1);
    @(negedge clk);
    chk({name, "_busy_falls"}, int'(busy), 0);
    repeat (3) @(negedge clk);
    chk({name, "_single_done"}, done_cnt - d0, 1);
    chk({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int w0;
    int o0;
    bit reached;
    rst_n              = 1'b1;
    frameStart         = 1'b0;
    activeRows         = '0;
    activeChunks       = '0;
    pixelConsumed      = 1'b0;
    rq.requestFifoFull = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_we",      int'(rq.requestFifoWriteEnable), 0);
    chk("rst_data",    int'(rq.requestFifoWriteData), 0);
    chk("rst_busy",    int'(busy), 0);
    chk("rst_done",    int'(frameDone), 0);
    chk("rst_overrun", int'(frameOverrun), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 2 rows x 3 chunks, free-running consumer
    exp_q.push_back(17'h00000);
    exp_q.push_back(17'h00001);
    exp_q.push_back(17'h00002);
    exp_q.push_back(17'h00040);
    exp_q.push_back(17'h00041);
    exp_q.push_back(17'h00042);
    w0 = n_writes;
    start_frame(2, 3);
    run_frame("r2c3", 2000, 1'b1, 1'b0, 1'b0);
    chk("r2c3_writes", n_writes - w0, 6);

    // Credit limit: 1 row x 10 chunks, consumer stalled
    push_frame(1, 10);
    w0 = n_writes;
    start_frame(1, 10);
    repeat (20) @(negedge clk);
    chk("credit_limit_writes", n_writes - w0, 4);
    for (int i = 0; i < 32; i++) begin
      pixelConsumed = 1'b1;
      @(negedge clk);
    end
    pixelConsumed = 1'b0;
    repeat (10) @(negedge clk);
    chk("credit_one_more", n_writes - w0, 5);
    run_frame("r1c10", 3000, 1'b1, 1'b0, 1'b0);

    // Full toggling every cycle
    push_frame(2, 4);
    check_full = 1'b1;
    start_frame(2, 4);
    run_frame("full_toggle", 3000, 1'b1, 1'b1, 1'b0);
    check_full = 1'b0;

    // Empty frames
    w0 = n_writes;
    start_frame(0, 5);
    chk("empty_rows_busy_c1", int'(busy), 1);
    chk("empty_rows_done_c1", int'(frameDone), 0);
    @(negedge clk);
    chk("empty_rows_busy_c2", int'(busy), 1);
    chk("empty_rows_done_c2", int'(frameDone), 1);
    @(negedge clk);
    chk("empty_rows_busy_c3", int'(busy), 0);
    chk("empty_rows_done_c3", int'(frameDone), 0);
    start_frame(3, 0);
    @(negedge clk);
    chk("empty_chunks_done_c2", int'(frameDone), 1);
    @(negedge clk);
    chk("empty_chunks_busy_c3", int'(busy), 0);
    repeat (2) @(negedge clk);
    chk("empty_no_writes", n_writes - w0, 0);

    // Overrun mid-frame at {1,1}; new config must not be latched
    push_frame(3, 3);
    o0 = ovr_cnt;
    w0 = n_writes;
    start_frame(3, 3);
    run_frame("overrun", 3000, 1'b1, 1'b0, 1'b1);
    chk("overrun_pulses", ovr_cnt - o0, 1);
    chk("overrun_writes", n_writes - w0, 9);

    // Reset mid-ISSUE with three chunks outstanding
    push_frame(2, 5);
    w0 = n_writes;
    start_frame(2, 5);
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (n_writes - w0 == 3) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("midreset_reached", int'(reached), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_we",      int'(rq.requestFifoWriteEnable), 0);
    chk("midreset_data",    int'(rq.requestFifoWriteData), 0);
    chk("midreset_busy",    int'(busy), 0);
    chk("midreset_done",    int'(frameDone), 0);
    chk("midreset_overrun", int'(frameOverrun), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_frame(1, 5);
    w0 = n_writes;
    start_frame(1, 5);
    repeat (20) @(negedge clk);
    chk("postreset_credit_writes", n_writes - w0, 4);
    run_frame("postreset", 3000, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
